// File: rtl/hilo_muldiv_unit_if.sv
// Operation request / HI-LO result bundle between the CPU datapath and hilo_muldiv_unit.
// The CPU drives the master side; the HI/LO unit implements the slave side.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             op_accept;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, rs_data, rt_data,
    input  op_accept, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data,
    output op_accept, busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with an iterative shift-add multiplier and restoring divider.
// Optional macro HILO_FAST_MULT_EN makes MULT/MULTU single-cycle; DIV/DIVU stay iterative.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  hilo_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic               is_div_reg, is_div_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  logic             busy;
  logic             accept;
  logic             signed_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign busy      = (state_reg != IDLE);
  assign accept    = bus.op_valid & clk_enable & ~busy & (bus.op != 3'd0) & (bus.op != 3'd7);
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign rs_neg    = signed_op & bus.rs_data[WIDTH-1];
  assign rt_neg    = signed_op & bus.rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_addend = acc_reg[0] ? opnd_reg : '0;
  assign mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_step   = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_step;
  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_step  = div_ge ? {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

  // Sign correction; a zero divisor leaves the all-ones quotient untouched
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fix = (neg_q_reg & ~div_zero_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{WIDTH{rs_neg}}, bus.rs_data};
  assign fast_b    = {{WIDTH{rt_neg}}, bus.rt_data};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    acc_next      = acc_reg;
    opnd_next     = opnd_reg;
    is_div_next   = is_div_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    div_zero_next = div_zero_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MTHI: hi_next = bus.rs_data;
            OP_MTLO: lo_next = bus.rs_data;
            OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
              {hi_next, lo_next} = fast_prod;
              done_next          = 1'b1;
`else
              acc_next      = {{WIDTH{1'b0}}, rt_mag};
              opnd_next     = rs_mag;
              is_div_next   = 1'b0;
              neg_q_next    = rs_neg ^ rt_neg;
              neg_r_next    = 1'b0;
              div_zero_next = 1'b0;
              count_next    = '0;
              state_next    = RUN;
`endif
            end
            default: begin
              acc_next      = {{WIDTH{1'b0}}, rs_mag};
              opnd_next     = rt_mag;
              is_div_next   = 1'b1;
              neg_q_next    = rs_neg ^ rt_neg;
              neg_r_next    = rs_neg;
              div_zero_next = (bus.rt_data == '0);
              count_next    = '0;
              state_next    = RUN;
            end
          endcase
        end
      end
      RUN: begin
        acc_next   = is_div_reg ? div_step : mul_step;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH-1))
          state_next = FIX;
      end
      FIX: begin
        if (is_div_reg) begin
          hi_next = rem_fix;
          lo_next = quot_fix;
        end else begin
          {hi_next, lo_next} = prod_fix;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else if (clk_enable) begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      acc_reg      <= acc_next;
      opnd_reg     <= opnd_next;
      is_div_reg   <= is_div_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      div_zero_reg <= div_zero_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  assign bus.op_accept = accept;
  assign bus.busy      = busy;
  assign bus.done      = done_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
endmodule
